// File: rtl/divider_config_ctrl_pkg.sv
// Shared types and constants for the divider configuration sequencer.
package div_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_STOP,
    ST_LOAD,
    ST_RESUME
  } state_e;

  // Matches the divisor the downstream divider assumes right after its own reset.
  localparam int unsigned DIV_RESET_VALUE = 1;

  localparam int unsigned SETTLE_MIN   = 1;
  localparam int unsigned SETTLE_MAX   = 255;
  localparam int unsigned SETTLE_CNT_W = 8;

endpackage

// File: rtl/divider_config_ctrl_if.sv
// Request side and divider-control side of the configuration sequencer.
interface divider_config_ctrl_if #(
  parameter int unsigned DIV_WIDTH = 32
);

  logic                 RunRequest;
  logic                 ReqValid;
  logic [DIV_WIDTH-1:0] ReqDiv;
  logic                 ReqReady;
  logic                 ReqError;
  logic                 Enable;
  logic                 ConfigDiv;
  logic [DIV_WIDTH-1:0] Dout;
  logic [DIV_WIDTH-1:0] CurrentDiv;
  logic                 Busy;

  modport master (
    output RunRequest, ReqValid, ReqDiv,
    input  ReqReady, ReqError, Enable, ConfigDiv, Dout, CurrentDiv, Busy
  );

  modport slave (
    input  RunRequest, ReqValid, ReqDiv,
    output ReqReady, ReqError, Enable, ConfigDiv, Dout, CurrentDiv, Busy
  );

endinterface

// File: rtl/divider_config_ctrl_settle_timer.sv
// 8-bit load/decrement counter with a zero flag; times the stop interval before a load.
import div_cfg_pkg::*;

module settle_timer (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [SETTLE_CNT_W-1:0] load_val,
  input  logic                    dec,
  output logic                    zero
);

  logic [SETTLE_CNT_W-1:0] count_q;
  logic [SETTLE_CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/divider_config_ctrl.sv
// Sequences divisor changes into the divider: stop, settle, one-cycle load, resume.
// All outputs are registered from the next state, so they are valid in the cycle a state is occupied.
import div_cfg_pkg::*;

module divider_config_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned DIV_WIDTH     = 32
) (
  input logic                  Clk,
  input logic                  Reset,
  divider_config_ctrl_if.slave bus
);

  if ((SETTLE_CYCLES < SETTLE_MIN) || (SETTLE_CYCLES > SETTLE_MAX)) begin : g_bad_settle
    $error("SETTLE_CYCLES out of legal range");
  end

  localparam logic [DIV_WIDTH-1:0]    DivReset  = DIV_WIDTH'(DIV_RESET_VALUE);
  localparam logic [SETTLE_CNT_W-1:0] SettleTop = SETTLE_CNT_W'(SETTLE_CYCLES - 1);

  state_e               state_q, state_d;
  logic                 enable_q, enable_d;
  logic                 config_div_q, config_div_d;
  logic [DIV_WIDTH-1:0] dout_q, dout_d;
  logic [DIV_WIDTH-1:0] current_div_q, current_div_d;
  logic                 req_ready_q, req_ready_d;
  logic                 req_error_q, req_error_d;
  logic                 busy_q, busy_d;

  logic accept;
  logic accept_ok;
  logic accept_zero;
  logic timer_load;
  logic timer_dec;
  logic timer_zero;

  settle_timer u_settle_timer (
    .clk      (Clk),
    .rst      (Reset),
    .load     (timer_load),
    .load_val (SettleTop),
    .dec      (timer_dec),
    .zero     (timer_zero)
  );

  always_comb begin
    state_d     = state_q;
    timer_load  = 1'b0;
    timer_dec   = 1'b0;
    accept      = bus.ReqValid & req_ready_q;
    accept_ok   = accept & (bus.ReqDiv != '0);
    accept_zero = accept & (bus.ReqDiv == '0);

    // A request takes priority over RunRequest; a rejected zero leaves the state alone.
    case (state_q)
      ST_IDLE: begin
        if (accept_ok) begin
          state_d = ST_LOAD;
        end else if (!accept_zero && bus.RunRequest) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (accept_ok) begin
          state_d    = ST_STOP;
          timer_load = 1'b1;
        end else if (!accept_zero && !bus.RunRequest) begin
          state_d = ST_IDLE;
        end
      end
      ST_STOP: begin
        if (timer_zero) begin
          state_d = ST_LOAD;
        end else begin
          timer_dec = 1'b1;
        end
      end
      ST_LOAD: begin
        state_d = ST_RESUME;
      end
      ST_RESUME: begin
        state_d = bus.RunRequest ? ST_RUN : ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    enable_d      = (state_d == ST_RUN);
    config_div_d  = (state_d == ST_LOAD);
    req_ready_d   = (state_d == ST_IDLE) || (state_d == ST_RUN);
    busy_d        = (state_d == ST_STOP) || (state_d == ST_LOAD) || (state_d == ST_RESUME);
    req_error_d   = accept_zero;
    dout_d        = accept_ok ? bus.ReqDiv : dout_q;
    current_div_d = (state_d == ST_RESUME) ? dout_q : current_div_q;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q       <= ST_IDLE;
      enable_q      <= 1'b0;
      config_div_q  <= 1'b0;
      dout_q        <= DivReset;
      current_div_q <= DivReset;
      req_ready_q   <= 1'b0;
      req_error_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      enable_q      <= enable_d;
      config_div_q  <= config_div_d;
      dout_q        <= dout_d;
      current_div_q <= current_div_d;
      req_ready_q   <= req_ready_d;
      req_error_q   <= req_error_d;
      busy_q        <= busy_d;
    end
  end

  assign bus.Enable     = enable_q;
  assign bus.ConfigDiv  = config_div_q;
  assign bus.Dout       = dout_q;
  assign bus.CurrentDiv = current_div_q;
  assign bus.ReqReady   = req_ready_q;
  assign bus.ReqError   = req_error_q;
  assign bus.Busy       = busy_q;

endmodule

// File: tb/tb_divider_config_ctrl.sv
// Directed bench for divider_config_ctrl with SETTLE_CYCLES=2; inputs change and outputs are sampled 1ns after each rising edge.
module tb_divider_config_ctrl;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_bad;

  divider_config_ctrl_if #(.DIV_WIDTH(32)) bus ();

  divider_config_ctrl #(
    .SETTLE_CYCLES (2),
    .DIV_WIDTH     (32)
  ) dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  logic [4:0] exp_en;
  logic [4:0] exp_cfg;
  logic [4:0] exp_busy;
  logic [4:0] exp_rdy;

  initial begin
    n_vec          = 0;
    n_bad          = 0;
    rst            = 1'b1;
    bus.RunRequest = 1'b0;
    bus.ReqValid   = 1'b0;
    bus.ReqDiv     = '0;
    repeat (3) tick();

    chk("rst_enable", 32'(bus.Enable), 0);
    chk("rst_config", 32'(bus.ConfigDiv), 0);
    chk("rst_dout", bus.Dout, 1);
    chk("rst_curdiv", bus.CurrentDiv, 1);
    chk("rst_ready", 32'(bus.ReqReady), 0);
    chk("rst_error", 32'(bus.ReqError), 0);
    chk("rst_busy", 32'(bus.Busy), 0);

    // Leave reset: ReqReady on the first cycle, Enable one cycle after RunRequest rises.
    rst = 1'b0;
    tick();
    chk("start_ready", 32'(bus.ReqReady), 1);
    chk("start_enable0", 32'(bus.Enable), 0);
    bus.RunRequest = 1'b1;
    tick();
    chk("start_enable1", 32'(bus.Enable), 1);
    chk("start_curdiv", bus.CurrentDiv, 1);
    chk("start_dout", bus.Dout, 1);
    bus.RunRequest = 1'b0;
    tick();
    chk("stop_enable", 32'(bus.Enable), 0);

    // Reconfigure from IDLE with divisor 6: LOAD, RESUME, back to IDLE.
    bus.ReqValid = 1'b1;
    bus.ReqDiv   = 32'd6;
    tick();
    bus.ReqValid = 1'b0;
    chk("idle_cfg_c1", 32'(bus.ConfigDiv), 1);
    chk("idle_dout_c1", bus.Dout, 6);
    chk("idle_en_c1", 32'(bus.Enable), 0);
    chk("idle_busy_c1", 32'(bus.Busy), 1);
    tick();
    chk("idle_cfg_c2", 32'(bus.ConfigDiv), 0);
    chk("idle_curdiv_c2", bus.CurrentDiv, 6);
    chk("idle_en_c2", 32'(bus.Enable), 0);
    tick();
    chk("idle_en_c3", 32'(bus.Enable), 0);
    chk("idle_ready_c3", 32'(bus.ReqReady), 1);
    chk("idle_busy_c3", 32'(bus.Busy), 0);

    bus.RunRequest = 1'b1;
    tick();
    chk("run_enable", 32'(bus.Enable), 1);

    // Reconfigure from RUN with divisor 5: STOP, STOP, LOAD, RESUME, RUN.
    exp_en   = 5'b10000;
    exp_cfg  = 5'b00100;
    exp_busy = 5'b01111;
    exp_rdy  = 5'b10000;
    bus.ReqValid = 1'b1;
    bus.ReqDiv   = 32'd5;
    tick();
    bus.ReqValid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) tick();
      chk($sformatf("run5_en_c%0d", i + 1), 32'(bus.Enable), 32'(exp_en[i]));
      chk($sformatf("run5_cfg_c%0d", i + 1), 32'(bus.ConfigDiv), 32'(exp_cfg[i]));
      chk($sformatf("run5_busy_c%0d", i + 1), 32'(bus.Busy), 32'(exp_busy[i]));
      if (i == 2) chk("run5_dout_load", bus.Dout, 5);
      if (i == 3) chk("run5_curdiv_resume", bus.CurrentDiv, 5);
    end

    // Zero divisor in RUN: one error pulse, nothing else moves.
    bus.ReqValid = 1'b1;
    bus.ReqDiv   = 32'd0;
    tick();
    bus.ReqValid = 1'b0;
    chk("zero_error", 32'(bus.ReqError), 1);
    chk("zero_enable", 32'(bus.Enable), 1);
    chk("zero_dout", bus.Dout, 5);
    chk("zero_curdiv", bus.CurrentDiv, 5);
    tick();
    chk("zero_error_end", 32'(bus.ReqError), 0);
    chk("zero_enable_end", 32'(bus.Enable), 1);

    // Divisor 4 accepted, then 9 held during the sequence until RUN accepts it.
    bus.ReqValid = 1'b1;
    bus.ReqDiv   = 32'd4;
    tick();
    bus.ReqDiv   = 32'd9;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) tick();
      chk($sformatf("hold_ready_c%0d", i + 1), 32'(bus.ReqReady), 32'(exp_rdy[i]));
      chk($sformatf("hold_en_c%0d", i + 1), 32'(bus.Enable), 32'(exp_en[i]));
      if (i == 2) chk("hold_dout_load", bus.Dout, 4);
      if (i == 3) chk("hold_curdiv_resume", bus.CurrentDiv, 4);
    end
    tick();
    bus.ReqValid = 1'b0;
    chk("hold9_dout", bus.Dout, 9);
    chk("hold9_enable", 32'(bus.Enable), 0);
    chk("hold9_busy", 32'(bus.Busy), 1);
    for (int i = 1; i < 5; i++) begin
      tick();
      chk($sformatf("seq9_en_c%0d", i + 1), 32'(bus.Enable), 32'(exp_en[i]));
      chk($sformatf("seq9_cfg_c%0d", i + 1), 32'(bus.ConfigDiv), 32'(exp_cfg[i]));
    end
    chk("seq9_curdiv", bus.CurrentDiv, 9);

    // Reset while in STOP with divisor 7 pending.
    bus.ReqValid = 1'b1;
    bus.ReqDiv   = 32'd7;
    tick();
    bus.ReqValid = 1'b0;
    chk("rst7_busy_stop", 32'(bus.Busy), 1);
    chk("rst7_dout_stop", bus.Dout, 7);
    rst = 1'b1;
    tick();
    chk("rst7_enable", 32'(bus.Enable), 0);
    chk("rst7_config", 32'(bus.ConfigDiv), 0);
    chk("rst7_dout", bus.Dout, 1);
    chk("rst7_curdiv", bus.CurrentDiv, 1);
    chk("rst7_busy", 32'(bus.Busy), 0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("rst7_nocfg_%0d", i), 32'(bus.ConfigDiv), 0);
      chk($sformatf("rst7_curdiv_%0d", i), bus.CurrentDiv, 1);
    end
    chk("rst7_running", 32'(bus.Enable), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/divider_config_ctrl.md
# divider_config_ctrl

Configuration sequencer that sits directly upstream of the frequency divider and drives its Enable, ConfigDiv and Din inputs. It accepts new divisor requests over a valid/ready handshake and applies each one with a safe sequence: stop the divider, hold it for a settle interval, pulse a one-cycle load, then resume. It also reports the divisor currently in force and rejects illegal (zero) divisors.

## Interface
- SETTLE_CYCLES, 2, cycles Enable is held low before a load when the divider was running; legal range 1..255
- DIV_WIDTH, 32, width of the divisor path
- Clk  in  1  single clock; every register in the block is clocked on its rising edge
- Reset  in  1  reset, synchronous and active-high
- RunRequest  in  1  level; high means the divider should be running
- ReqValid  in  1  a new divisor is offered on ReqDiv
- ReqDiv  in  DIV_WIDTH  requested divisor
- ReqReady  out  1  block can accept a request this cycle
- ReqError  out  1  one-cycle pulse when a zero divisor is rejected
- Enable  out  1  to divider Enable
- ConfigDiv  out  1  to divider ConfigDiv; high for exactly one cycle per load
- Dout  out  DIV_WIDTH  to divider Din
- CurrentDiv  out  DIV_WIDTH  divisor most recently loaded
- Busy  out  1  high while a reconfiguration sequence is in progress

## Operation
- All outputs are registered.
- Reset values: Enable=0, ConfigDiv=0, Dout=1, CurrentDiv=1, ReqReady=0, ReqError=0, Busy=0, state IDLE, settle counter 0. ReqReady rises on the first cycle after Reset deasserts.
- **IDLE** (Enable=0, ReqReady=1):
  - An accept (ReqValid & ReqReady) with nonzero ReqDiv goes to LOAD.
  - Otherwise, RunRequest=1 goes to RUN.
- **RUN** (Enable=1, ReqReady=1):
  - A nonzero accept goes to STOP and loads the settle counter with SETTLE_CYCLES-1.
  - Otherwise, RunRequest=0 goes to IDLE.
- **STOP** (Enable=0, Busy=1, ReqReady=0): the counter decrements each cycle; at 0 the block goes to LOAD.
- **LOAD** (ConfigDiv=1, Enable=0, Busy=1): the next state is RESUME.
- **RESUME** (ConfigDiv=0, Enable=0, Busy=1):
  - CurrentDiv is updated to the pending divisor.
  - The next state is RUN if RunRequest=1, otherwise IDLE.
- Pending divisor: captured into Dout on the accept edge. Dout holds that value until the next accepted request; it never changes while ConfigDiv=1.
- Zero divisor: ReqError pulses on the cycle after the accept. No state change, and Dout and CurrentDiv are unchanged. The handshake still completes, so the requester is not stalled.
- Simultaneous events:
  - An accept in the same cycle as a RunRequest edge: the request wins. RunRequest is sampled only in RESUME, IDLE and RUN.
  - ReqValid while Busy is ignored (ReqReady=0). The requester must hold the request until it is accepted.
- Reset mid-sequence (any state): all outputs return to their reset values on the next edge. Enable and ConfigDiv are 0 from that edge onward, and no partial load is reported in CurrentDiv.

## Timing
- Registered outputs mean a state's outputs appear on the cycle after the transition edge.
- Reconfigure from RUN:
  - Enable falls one cycle after the accept.
  - Enable stays low for SETTLE_CYCLES+2 cycles (STOP ×SETTLE_CYCLES, then LOAD, then RESUME).
  - ConfigDiv is high in cycle SETTLE_CYCLES+1 after the accept.
  - Enable is high again SETTLE_CYCLES+3 cycles after the accept.
- Reconfigure from IDLE: ConfigDiv is high one cycle after the accept; CurrentDiv updates the cycle after that.
- Start and stop: Enable follows a RunRequest change with 1 cycle of latency (IDLE↔RUN).
- Throughput: at most one reconfiguration per SETTLE_CYCLES+3 cycles from RUN, or one per 3 cycles from IDLE.

## Structure
- Package div_cfg_pkg holds:
  - the state enum (IDLE, RUN, STOP, LOAD, RESUME);
  - DIV_RESET_VALUE = 1, which matches the divider's post-reset target;
  - the SETTLE_CYCLES legality bounds.
- One sub-module, settle_timer: an 8-bit load/decrement counter with a zero flag, instantiated once. Everything else lives in the top FSM.

## Test plan
- Reset, then RunRequest=1 → Enable=1 two cycles after Reset deasserts; CurrentDiv=1; Dout=1.
- IDLE, with ReqValid=1 and ReqDiv=6 for one cycle → ConfigDiv high for 1 cycle with Dout=6; CurrentDiv=6; Enable never asserts.
- RUN, with SETTLE_CYCLES=2 and ReqDiv=5 → Enable low for exactly 4 cycles; ConfigDiv high in the 3rd of them with Dout=5; Enable high again; Busy high for those 4 cycles.
- ReqDiv=0 accepted in RUN → ReqError one pulse; Enable stays 1; Dout and CurrentDiv unchanged.
- ReqValid held during Busy with ReqDiv=9 → ReqReady=0 until RUN is reached; then 9 is accepted and a second full sequence runs.
- Reset asserted during STOP with ReqDiv=7 pending → next cycle Enable=0, ConfigDiv=0, Dout=1, CurrentDiv=1; no ConfigDiv pulse is ever seen.
